dmem_responder: RTL and testbench

- Data-memory responder for the Riscv151 core: the memory-side end of the CPU load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake and performs byte-lane masking on stores.
- On loads it extracts the byte or halfword and sign- or zero-extends it, then returns the result with a fixed two-cycle latency.
- Owns the synchronous data SRAM array data_mem, word-indexed and DEPTH_WORDS deep. Benches probe data_mem directly.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store request and response bundle between the CPU (master)
// and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_error;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_error
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the Riscv151 core: serialized load/store with
// byte-lane masking, load extension and a fixed two-cycle response latency.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;

  logic [31:0] data_mem [DEPTH_WORDS];
  logic [31:0] mem_rdata_q;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]  offset;
  logic [4:0]  shift;
  logic        illegal;
  logic        out_of_range;
  logic        err;
  logic        misaligned;
  logic [31:0] lane_mask;
  logic [31:0] load_mask;
  logic [31:0] store_data;
  logic [3:0]  byte_en;
  logic [31:0] raw;
  logic [31:0] ext;
  logic        wr_en;
  logic        rd_en;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
    end
  end

  always_comb begin
    word_idx     = addr_q[ADDR_WIDTH+1:2];
    offset       = addr_q[1:0];
    shift        = {offset, 3'b000};
    illegal      = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) ||
                   (we_q && (funct3_q[2:1] == 2'b10));
    out_of_range = |addr_q[31:ADDR_WIDTH+2];
    err          = illegal || out_of_range;

    // A misaligned word access gets an empty mask, which suppresses both write and read data.
    case (funct3_q[1:0])
      2'b00:   lane_mask = 32'h0000_00FF << shift;
      2'b01:   lane_mask = 32'h0000_FFFF << shift;
      default: lane_mask = (offset == 2'd0) ? 32'hFFFF_FFFF : 32'h0000_0000;
    endcase

    misaligned = !err &&
                 (((funct3_q[1:0] == 2'b01) && (offset == 2'd3)) ||
                  ((funct3_q[1:0] == 2'b10) && (offset != 2'd0)));

    load_mask  = ((funct3_q[1:0] == 2'b01) && (offset == 2'd3)) ? 32'h0 : lane_mask;
    store_data = wdata_q << shift;
    byte_en    = {|lane_mask[31:24], |lane_mask[23:16], |lane_mask[15:8], |lane_mask[7:0]};
    wr_en      = (state_q == ST_ACCESS) && we_q && !err;
    rd_en      = (state_q == ST_ACCESS) && !we_q;

    raw = (mem_rdata_q & load_mask) >> shift;
    case (funct3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // SRAM array: byte-enabled write and registered read, both on the edge leaving ACCESS.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          data_mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      mem_rdata_q <= data_mem[word_idx];
    end
  end

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.resp_valid      = (state_q == ST_RESP);
  assign bus.resp_rdata      = ((state_q == ST_RESP) && !we_q && !err) ? ext : 32'd0;
  assign bus.resp_misaligned = (state_q == ST_RESP) && misaligned;
  assign bus.resp_error      = (state_q == ST_RESP) && err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a negedge monitor pops and compares each response pulse.
module tb_dmem_responder;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          accept;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   edge_cnt = 0;
  exp_t sb [$];

  dmem_if bus ();

  dmem_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(16384)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        checkOutput({e.name, "_mis"}, {31'd0, bus.resp_misaligned}, {31'd0, e.mis});
        checkOutput({e.name, "_err"}, {31'd0, bus.resp_error}, {31'd0, e.err});
        checkOutput({e.name, "_latency"}, edge_cnt - e.accept, 32'd2);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_err);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      checkOutput({name, "_ready_timeout"}, {31'd0, bus.req_ready}, 32'd1);
    end else begin
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      e.name   = name;
      e.rdata  = exp_rdata;
      e.mis    = exp_mis;
      e.err    = exp_err;
      e.accept = edge_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput({name, "_drain"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] sh_exp [4];
    logic [31:0] lb_exp [4];
    logic [31:0] lbu_exp [4];
    logic [31:0] lh_exp [4];
    logic [31:0] lhu_exp [4];
    sh_exp  = '{32'hAAAA3344, 32'hAA3344AA, 32'h3344AAAA, 32'h44AAAAAA};
    lb_exp  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    lbu_exp = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
    lh_exp  = '{32'h00007F01, 32'hFFFFFF7F, 32'hFFFF80FF, 32'h00000000};
    lhu_exp = '{32'h00007F01, 32'h0000FF7F, 32'h000080FF, 32'h00000000};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("reset_rdata", bus.resp_rdata, 32'd0);
    checkOutput("reset_mis", {31'd0, bus.resp_misaligned}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.resp_error}, 32'd0);
    rst = 1'b0;

    $display("[TB] byte and halfword loads");
    applyStimulus("sw_init0", 1'b1, 32'd0, 32'h80FF7F01, 3'b010, 32'd0, 1'b0, 1'b0);
    for (int o = 0; o < 4; o++) begin
      applyStimulus($sformatf("lb_%0d", o), 1'b0, o, 32'd0, 3'b000, lb_exp[o], 1'b0, 1'b0);
      applyStimulus($sformatf("lbu_%0d", o), 1'b0, o, 32'd0, 3'b100, lbu_exp[o], 1'b0, 1'b0);
    end
    for (int o = 0; o < 4; o++) begin
      applyStimulus($sformatf("lh_%0d", o), 1'b0, o, 32'd0, 3'b001, lh_exp[o], o == 3, 1'b0);
      applyStimulus($sformatf("lhu_%0d", o), 1'b0, o, 32'd0, 3'b101, lhu_exp[o], o == 3, 1'b0);
    end
    drain("loads");

    $display("[TB] halfword stores");
    for (int o = 0; o < 4; o++) begin
      applyStimulus($sformatf("sw_aa_%0d", o), 1'b1, 32'd4, 32'hAAAAAAAA, 3'b010, 32'd0, 1'b0, 1'b0);
      applyStimulus($sformatf("sh_%0d", o), 1'b1, 32'd4 + o, 32'h11223344, 3'b001, 32'd0, o == 3, 1'b0);
      drain($sformatf("sh_%0d", o));
      checkOutput($sformatf("mem1_after_sh_%0d", o), dut.data_mem[1], sh_exp[o]);
    end

    $display("[TB] word store/load and misaligned word");
    applyStimulus("sw_8", 1'b1, 32'd8, 32'h11223344, 3'b010, 32'd0, 1'b0, 1'b0);
    applyStimulus("lw_8", 1'b0, 32'd8, 32'd0, 3'b010, 32'h11223344, 1'b0, 1'b0);
    applyStimulus("sw_9", 1'b1, 32'd9, 32'hDEADBEEF, 3'b010, 32'd0, 1'b1, 1'b0);
    applyStimulus("lw_9", 1'b0, 32'd9, 32'd0, 3'b010, 32'd0, 1'b1, 1'b0);
    drain("word");
    checkOutput("mem2_after_sw9", dut.data_mem[2], 32'h11223344);

    $display("[TB] error cases");
    applyStimulus("sbu_err", 1'b1, 32'd0, 32'h12345678, 3'b100, 32'd0, 1'b0, 1'b1);
    applyStimulus("lw_oor", 1'b0, 32'h00010000, 32'd0, 3'b010, 32'd0, 1'b0, 1'b1);
    applyStimulus("ld_f3_011", 1'b0, 32'd0, 32'd0, 3'b011, 32'd0, 1'b0, 1'b1);
    applyStimulus("sw_oor", 1'b1, 32'h00010000, 32'h55555555, 3'b010, 32'd0, 1'b0, 1'b1);
    drain("errors");
    checkOutput("mem0_after_err", dut.data_mem[0], 32'h80FF7F01);

    $display("[TB] reset during access");
    applyStimulus("sw_12_init", 1'b1, 32'd12, 32'hCAFEBABE, 3'b010, 32'd0, 1'b0, 1'b0);
    drain("sw_12_init");
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'd12;
    bus.req_wdata  = 32'h01234567;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rst_mid_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mem3_after_rst", dut.data_mem[3], 32'hCAFEBABE);
    applyStimulus("lw_12_after_rst", 1'b0, 32'd12, 32'd0, 3'b010, 32'hCAFEBABE, 1'b0, 1'b0);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
